// File: rtl/countdown_timer.sv
// countdown_timer: loadable mm:ss down-counter driven by a 1 Hz tick strobe
//   clk, reset         : system clock, synchronous active-high reset
//   tick               : one-cycle 1 Hz strobe, counts only in RUN
//   load/load_min/sec  : capture a new count (clamped to MAX_MIN:59), ignored in RUN
//   start/pause/clear  : run control; clear aborts to IDLE with 00:00
//   min_out/sec_out    : current count, binary
//   running/expired    : high in RUN / sticky high in EXPIRED
//   done               : one-cycle pulse when the count reaches 00:00
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on expiry.
module countdown_timer #(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [5:0] min_out,
   output logic [5:0] sec_out,
   output logic       running,
   output logic       expired,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
   localparam logic [5:0] MAX_M = 6'(MAX_MIN);
   state_t state;
   logic [5:0] ld_min, ld_sec, dec_min, dec_sec, rl_min, rl_sec;
   logic dec_zero, rl_zero;
   always_comb begin
      ld_min   = load_min > MAX_M ? MAX_M : load_min;
      ld_sec   = load_sec > 6'd59 ? 6'd59 : load_sec;
      dec_sec  = sec_out != 6'd0 ? sec_out - 6'd1 : 6'd59;
      dec_min  = sec_out != 6'd0 ? min_out : min_out - 6'd1;
      dec_zero = dec_min == 6'd0 && dec_sec == 6'd0;
      rl_zero  = rl_min == 6'd0 && rl_sec == 6'd0;
   end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rl_min <= '0;
         rl_sec <= '0;
      end else if (!clear && load && state != RUN) begin
         rl_min <= ld_min;
         rl_sec <= ld_sec;
      end
   end
`else
   assign rl_min = '0;
   assign rl_sec = '0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         min_out <= '0;
         sec_out <= '0;
         running <= 1'b0;
         expired <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            min_out <= '0;
            sec_out <= '0;
            running <= 1'b0;
            expired <= 1'b0;
         end else if (load && state != RUN) begin
            state   <= IDLE;
            min_out <= ld_min;
            sec_out <= ld_sec;
            running <= 1'b0;
            expired <= 1'b0;
         end else if (pause && state == RUN) begin
            state   <= PAUSED;
            running <= 1'b0;
         end else if (start && (state == IDLE || state == PAUSED) && (min_out != 6'd0 || sec_out != 6'd0)) begin
            state   <= RUN;
            running <= 1'b1;
         end else if (tick && state == RUN) begin
            // a zero reload value (always so without auto-reload) makes expiry sticky
            min_out <= dec_zero ? rl_min : dec_min;
            sec_out <= dec_zero ? rl_sec : dec_sec;
            done    <= dec_zero;
            if (dec_zero && rl_zero) begin
               state   <= EXPIRED;
               running <= 1'b0;
               expired <= 1'b1;
            end
         end
      end
   end
endmodule
